// File: rtl/mem_port_arbiter.sv
// Shares one single-ported fixed-latency unified memory between the fetch and data ports.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data always beats fetch.
module mem_port_arbiter #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                owner_dm_q;
    logic                sel_hi_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                if_valid_q;
    logic                dm_valid_q;
    logic [31:0]         if_rdata_q;
    logic [DATA_W-1:0]   dm_rdata_q;
`ifdef MEM_ARB_RR_EN
    logic                rr_if_first_q;
`endif

    // Low address bits never reach the memory: accesses are doubleword aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], dm_addr[2:0]};

    // Grant is decided combinationally whenever the memory is not busy.
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (state_q != ACCESS) begin
`ifdef MEM_ARB_RR_EN
            if (dm_req && (!if_req || !rr_if_first_q)) begin
                dm_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
`else
            if (dm_req) begin
                dm_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
`endif
        end
    end

    assign stall     = (state_q == ACCESS) | if_req | dm_req;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_dm_q  <= 1'b1;
            sel_hi_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
            rr_if_first_q <= 1'b0;
`endif
        end else begin
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            case (state_q)
                ACCESS: begin
                    if (cnt_q == '0) begin
                        state_q  <= DONE;
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        if (owner_dm_q) begin
                            dm_valid_q <= 1'b1;
                            if (!mem_we_q) begin
                                dm_rdata_q <= mem_rdata;
                            end
                        end else begin
                            if_valid_q <= 1'b1;
                            if_rdata_q <= sel_hi_q ? mem_rdata[63:32] : mem_rdata[31:0];
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    // IDLE and DONE share arbitration so back-to-back accesses have no bubble.
                    if (dm_gnt || if_gnt) begin
                        state_q    <= ACCESS;
                        cnt_q      <= CNT_INIT;
                        mem_en_q   <= 1'b1;
                        owner_dm_q <= dm_gnt;
`ifdef MEM_ARB_RR_EN
                        rr_if_first_q <= dm_gnt;
`endif
                        if (dm_gnt) begin
                            mem_we_q   <= dm_we;
                            mem_addr_q <= {dm_addr[ADDR_W-1:3], 3'b000};
                            if (dm_we) begin
                                mem_wdata_q <= dm_wdata;
                            end
                        end else begin
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= {if_addr[ADDR_W-1:3], 3'b000};
                            sel_hi_q   <= if_addr[2];
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates between the instruction-fetch port and the data-memory port of the 5-stage pipelined RISC-V core so both can share one single-ported, fixed-latency unified memory.
- Sequences each access over LATENCY cycles, returns read data or a write acknowledge to the winning requester, and drives a stall to the pipeline while any access is outstanding.
- Sits between the PC/IF stage and EX/MEM stage on one side and the unified memory macro on the other.

Parameters:
- LATENCY, 2, memory access cycles (mem_en held high); legal range 1..15
- ADDR_W, 64, address width
- DATA_W, 64, memory data width; fixed at 64

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch byte address
- if_gnt  out  1  fetch accepted, one-cycle pulse
- if_valid  out  1  fetch data valid, one-cycle pulse
- if_rdata  out  32  fetched instruction
- dm_req  in  1  data request
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data byte address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  data accepted, one-cycle pulse
- dm_valid  out  1  load data valid or store acknowledge, one-cycle pulse
- dm_rdata  out  DATA_W  load data
- mem_en  out  1  memory access active
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  doubleword-aligned address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in the last access cycle
- stall  out  1  pipeline stall

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high.
- Reset values: state=IDLE, all outputs 0, if_rdata/dm_rdata 0, owner=data.
- States: IDLE, ACCESS, DONE.
- IDLE/DONE arbitration (same rule in both states):
  - dm_req has priority over if_req.
  - Winner gets a gnt pulse the same cycle (combinational from req and state).
  - On the grant edge, latch addr, we and wdata (stores only), owner, and cnt=LATENCY-1, then go to ACCESS.
  - No request: go to IDLE.
- ACCESS:
  - mem_en=1, mem_addr={latched_addr[ADDR_W-1:3],3'b000}.
  - mem_we=latched we (fetches always 0), mem_wdata=latched wdata.
  - cnt decrements each cycle. When cnt==0, capture mem_rdata and go to DONE.
- DONE: one cycle with owner's valid=1, and the arbitration for the next access happens in this same cycle, so back-to-back accesses have no idle bubble.
- Read return:
  - if_rdata = latched if_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0].
  - dm_rdata = full mem_rdata.
  - Rdata registers hold their value until the next capture.
  - Store: dm_valid pulses; dm_rdata is unchanged.
- Requester contract:
  - req, addr, we and wdata stay stable until gnt.
  - The arbiter samples them only on the grant edge.
  - req still high in the cycle after gnt is treated as a new request.
- Simultaneous requests: dm served first; if_req stays pending and is granted in the DONE cycle of the data access.
- stall = (state==ACCESS) | if_req | dm_req, evaluated in IDLE/DONE. So stall is asserted from the request cycle through the cycle before DONE, and also in DONE when a new grant occurs.
- Latency: request to valid is LATENCY+1 cycles when the arbiter is idle.
- Misaligned dm_addr (bits[2:0]≠0): access issued to the aligned doubleword; no fault.
- Reset mid-access: next state IDLE, mem_en drops the following cycle, no valid pulse, pending grants lost.
- LATENCY=1: ACCESS lasts exactly one cycle.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. On simultaneous requests, the requester that was not the last owner wins; ties after reset go to data. Prevents fetch starvation under back-to-back loads.
- Undefined: fixed data-over-fetch priority as above.

Test Plan:
- LATENCY=2, idle, if_req with if_addr=0x4, mem_rdata=0xAAAA_BBBB_1111_2222 -> if_gnt at cycle 0; mem_en cycles 1-2; if_valid at cycle 3 with if_rdata=0xAAAA_BBBB; stall high cycles 0-2.
- dm_req store, dm_addr=0x10, dm_wdata=0xDEAD -> mem_we=1, mem_addr=0x10, mem_wdata=0xDEAD for 2 cycles; dm_valid pulse; dm_rdata unchanged.
- Simultaneous if_req (addr 0x0) and dm_req load (addr 0x20) -> dm_gnt first; if_gnt in the dm DONE cycle; if_valid 3 cycles after that; no idle cycle between accesses.
- reset asserted in the second ACCESS cycle -> next cycle: IDLE, mem_en=0, stall=0, no valid pulse.
- MEM_ARB_RR_EN defined, dm_req and if_req held continuously -> grants alternate dm, if, dm, if; undefined -> dm granted every time.
- LATENCY=1, back-to-back fetches at 0x0 and 0x8 -> if_valid every 2 cycles, correct low-half instructions.
